ms_tick_gen: RTL and testbench

//   Parametrised millisecond timebase for the heart-rate datapath.

---
 rtl/ms_tick_gen.sv | 99 +++++++++
 tb/tb_ms_tick_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ms_tick_gen.sv
// Millisecond timebase: divides clk to TICK_HZ and produces an enable tick, a 50% square
// wave, a wrapping ms timestamp and a runtime-programmable slow tick (every div ms).
module ms_tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int MSW     = 32,
  parameter int DIVW    = 16,
  parameter int DIV_RST = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            sync_clr,
  input  logic [DIVW-1:0] div_in,
  input  logic            div_load,
  output logic            div_busy,
  output logic            ms_tick,
  output logic            sq_out,
  output logic            slow_tick,
  output logic [MSW-1:0]  ms_count
);

  localparam int HALF = CLK_HZ / (2 * TICK_HZ);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  logic [CW-1:0]   cnt;
  logic [DIVW-1:0] div;
  logic [DIVW-1:0] shadow;
  logic [DIVW-1:0] slow_cnt;
  logic            wrap;
  logic            boundary;
  logic            slow_hit;
  logic [DIVW-1:0] pending_div;

  always_comb begin
    wrap        = (cnt == HALF_M1);
    boundary    = en && wrap && !sq_out;
    slow_hit    = (div != '0) && (slow_cnt == div - DIVW'(1));
    // A same-cycle load is newer than anything already sitting in the shadow.
    pending_div = div_load ? div_in : shadow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sq_out    <= 1'b0;
      ms_tick   <= 1'b0;
      slow_tick <= 1'b0;
      ms_count  <= '0;
      slow_cnt  <= '0;
      div       <= DIVW'(DIV_RST);
      shadow    <= '0;
      div_busy  <= 1'b0;
    end else if (sync_clr) begin
      cnt       <= '0;
      sq_out    <= 1'b0;
      ms_tick   <= 1'b0;
      slow_tick <= 1'b0;
      ms_count  <= '0;
      slow_cnt  <= '0;
      if (div_load || div_busy) begin
        div      <= pending_div;
        div_busy <= 1'b0;
      end
    end else begin
      if (en) begin
        if (wrap) begin
          cnt    <= '0;
          sq_out <= !sq_out;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      ms_tick   <= boundary;
      slow_tick <= 1'b0;
      if (boundary) begin
        ms_count <= ms_count + MSW'(1);
        // Applying a new divisor restarts the slow phase and swallows this edge's slow tick.
        if (div_load || div_busy) begin
          div      <= pending_div;
          slow_cnt <= '0;
          div_busy <= 1'b0;
        end else if (div != '0) begin
          if (slow_hit) begin
            slow_cnt  <= '0;
            slow_tick <= 1'b1;
          end else begin
            slow_cnt <= slow_cnt + DIVW'(1);
          end
        end
      end else if (div_load) begin
        shadow   <= div_in;
        div_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ms_tick_gen.sv
// Bench for ms_tick_gen at CLK_HZ=20, TICK_HZ=2 (HALF=5), DIV_RST=3, MSW=3: directed steps
// followed by random traffic, all checked against a time-based reference model.
module tb_ms_tick_gen;
  localparam int H    = 5;
  localparam int MSW  = 3;
  localparam int DIVW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            en = 1'b0;
  logic            sync_clr = 1'b0;
  logic [DIVW-1:0] div_in = '0;
  logic            div_load = 1'b0;
  logic            div_busy;
  logic            ms_tick;
  logic            sq_out;
  logic            slow_tick;
  logic [MSW-1:0]  ms_count;

  ms_tick_gen #(
    .CLK_HZ(20), .TICK_HZ(2), .MSW(MSW), .DIVW(DIVW), .DIV_RST(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .div_in(div_in),
    .div_load(div_load), .div_busy(div_busy), .ms_tick(ms_tick), .sq_out(sq_out),
    .slow_tick(slow_tick), .ms_count(ms_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  // Model: r = enabled edges since reset/clear; k = ms ticks since the slow phase restarted.
  int r, k, mdiv, mshadow;
  bit mbusy, etick, eslow;
  int cyc;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    r = 0; k = 0; mdiv = 3; mshadow = 0; mbusy = 0; etick = 0; eslow = 0;
  endtask

  task automatic model_edge();
    bit bnd;
    if (!rst_n) begin
      model_reset();
    end else if (sync_clr) begin
      r = 0; k = 0; etick = 0; eslow = 0;
      if (div_load) begin mdiv = int'(div_in); mbusy = 0; end
      else if (mbusy) begin mdiv = mshadow; mbusy = 0; end
    end else begin
      if (en) r++;
      bnd = en && (r % (2 * H) == H);
      etick = bnd;
      eslow = 0;
      if (bnd) begin
        if (div_load) begin mdiv = int'(div_in); mbusy = 0; k = 0; end
        else if (mbusy) begin mdiv = mshadow; mbusy = 0; k = 0; end
        else if (mdiv != 0) begin k++; eslow = (k % mdiv == 0); end
      end else if (div_load) begin
        mshadow = int'(div_in); mbusy = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("ms_tick", int'(ms_tick), int'(etick));
    chk("sq_out", int'(sq_out), (r / H) % 2);
    chk("slow_tick", int'(slow_tick), int'(eslow));
    chk("ms_count", int'(ms_count), ((r + H) / (2 * H)) % (1 << MSW));
    chk("div_busy", int'(div_busy), int'(mbusy));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    run(2);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    #1 rst_n = 1'b0;
    en = 1'b1;
    run(3);
    rst_n = 1'b1;
    cyc = 0;

    // Free run: ticks at 5, 15, 25...; slow tick every 3rd ms tick.
    run(4);
    chk("pre_first_tick", int'(ms_tick), 0);
    step();
    chk("first_tick_c5", int'(ms_tick), 1);
    chk("first_count", int'(ms_count), 1);
    run(60);

    // Divisor load 2 at cycle 7: busy until boundary 15, next slow tick at 35.
    do_reset();
    run(6);
    div_in = 4'd2; div_load = 1'b1;
    step();
    div_load = 1'b0;
    chk("busy_after_load", int'(div_busy), 1);
    run(8);
    chk("busy_clear_c15", int'(div_busy), 0);
    run(19);
    chk("no_slow_c34", int'(slow_tick), 0);
    step();
    chk("slow_c35", int'(slow_tick), 1);
    run(10);

    // Enable gap of 7 cycles mid-period.
    run(3);
    en = 1'b0;
    run(7);
    en = 1'b1;
    run(20);

    // Clear with same-cycle load of 0: slow tick disabled, next ms tick 5 cycles later.
    sync_clr = 1'b1; div_in = 4'd0; div_load = 1'b1;
    step();
    sync_clr = 1'b0; div_load = 1'b0;
    chk("clr_count", int'(ms_count), 0);
    chk("clr_busy", int'(div_busy), 0);
    run(4);
    step();
    chk("tick_after_clr", int'(ms_tick), 1);
    run(40);

    // Wrap of the 3-bit timestamp on the 8th tick (cycle 75).
    do_reset();
    run(74);
    chk("count_before_wrap", int'(ms_count), 7);
    step();
    chk("count_wrap", int'(ms_count), 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      sync_clr = ($urandom_range(0, 79) == 0);
      div_load = ($urandom_range(0, 11) == 0);
      div_in   = DIVW'($urandom_range(0, 4));
      step();
    end
    en = 1'b1; sync_clr = 1'b0; div_load = 1'b0;
    run(7);

    // Asynchronous reset mid-period.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_ms_tick", int'(ms_tick), 0);
    chk("async_sq_out", int'(sq_out), 0);
    chk("async_count", int'(ms_count), 0);
    chk("async_slow", int'(slow_tick), 0);
    chk("async_busy", int'(div_busy), 0);
    run(2);
    rst_n = 1'b1;
    run(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
